// File: rtl/mant_align_seq.sv
// Iterative mantissa aligner: right-shifts up to STEP bits/cycle, optional two's complement, valid/ready on both sides.
// Latency ceil(eff/STEP)+2 edges counting the accept edge; holds its result in DONE until out_ready; sticky gated by MANT_ALIGN_STICKY_EN.
module mant_align_seq #(
  parameter int MW   = 11,
  parameter int EW   = 5,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] mant_in,
  input  logic [EW-1:0] shamt,
  input  logic          sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] mant_out,
  output logic          sticky
);

  localparam int CW = $clog2(MW + 1);
  localparam int SW = (EW > CW) ? EW : CW;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [MW-1:0] ONE    = MW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMP, DONE} state_t;

  state_t        state;
  logic [MW-1:0] work;
  logic [CW-1:0] rem;
  logic          sub_q;

  logic [SW-1:0] shamt_x;
  logic [CW-1:0] eff;
  logic [CW-1:0] k;
  logic [MW-1:0] shifted;
  logic [MW-1:0] result;

  // Shift amounts at or beyond MW all collapse to a full flush of the mantissa.
  always_comb begin
    shamt_x = SW'(shamt);
    eff     = (shamt_x >= SW'(MW)) ? CW'(MW) : CW'(shamt_x);
    k       = (rem > STEP_C) ? STEP_C : rem;
    shifted = work >> k;
    result  = sub_q ? (~work + ONE) : work;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mant_out  <= '0;
      work      <= '0;
      rem       <= '0;
      sub_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= mant_in;
            sub_q    <= sub;
            rem      <= eff;
            in_ready <= 1'b0;
            state    <= (eff != '0) ? SHIFT : COMP;
          end
        end
        SHIFT: begin
          work <= shifted;
          rem  <= rem - k;
          if (rem == k) state <= COMP;
        end
        COMP: begin
          work      <= result;
          mant_out  <= result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MANT_ALIGN_STICKY_EN
  logic          sticky_q;
  logic [MW-1:0] out_mask;

  // Bits about to fall off the LSB end this cycle; taken before any complement.
  always_comb begin
    out_mask = ~({MW{1'b1}} << k);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid && in_ready) sticky_q <= 1'b0;
        SHIFT:   sticky_q <= sticky_q | (|(work & out_mask));
        COMP:    sticky   <= sticky_q;
        default: ;
      endcase
    end
  end
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mant_align_seq.sv
// Directed bench for mant_align_seq (MW=11) at STEP=1 and STEP=4, expectations hand-computed.
module tb_mant_align_seq;

`ifdef MANT_ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, sticky;
  logic [10:0] mant_in, mant_out;
  logic [4:0]  shamt;

  logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, sticky4;
  logic [10:0] mant_in4, mant_out4;
  logic [4:0]  shamt4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mant_align_seq #(.MW(11), .EW(5), .STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .mant_in(mant_in), .shamt(shamt), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .mant_out(mant_out), .sticky(sticky)
  );

  mant_align_seq #(.MW(11), .EW(5), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .mant_in(mant_in4), .shamt(shamt4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4), .mant_out(mant_out4), .sticky(sticky4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents an operand and returns #1 after the accept edge.
  task automatic accept(input logic [10:0] m, input logic [4:0] s, input logic b);
    int g;
    @(negedge clk);
    mant_in  = m;
    shamt    = s;
    sub      = b;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic wait_valid(output int e);
    e = 1;
    while (!out_valid && e < 200) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic run_op(input string tag, input logic [10:0] m, input logic [4:0] s, input logic b,
                        input logic [10:0] em, input logic es, input int el);
    int e;
    accept(m, s, b);
    wait_valid(e);
    chk({tag, "_lat"}, e, el);
    chk({tag, "_mant"}, mant_out, em);
    chk({tag, "_sticky"}, sticky, es & STK);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 1'b0);
    chk({tag, "_keep"}, mant_out, em);
  endtask

  task automatic run4(input string tag, input logic [10:0] m, input logic [4:0] s, input logic b,
                      input logic [10:0] em, input logic es, input int el);
    int e;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready4, 1'b1);
    mant_in4  = m;
    shamt4    = s;
    sub4      = b;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    e = 1;
    while (!out_valid4 && e < 200) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk({tag, "_lat"}, e, el);
    chk({tag, "_mant"}, mant_out4, em);
    chk({tag, "_sticky"}, sticky4, es & STK);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst_n = 1'b0; in_valid = 1'b0; mant_in = '0; shamt = '0; sub = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; mant_in4 = '0; shamt4 = '0; sub4 = 1'b0; out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mant", mant_out, 11'h000);
    chk("rst_sticky", sticky, 1'b0);
    rst_n = 1'b1;

    run_op("t1_shift3",   11'h400, 5'd3,  1'b0, 11'h080, 1'b0, 5);
    run_op("t2_sub",      11'h0F0, 5'd4,  1'b1, 11'h7F1, 1'b0, 6);
    run_op("t3_sticky",   11'h003, 5'd2,  1'b0, 11'h000, 1'b1, 4);
    run_op("t4_overflow", 11'h7FF, 5'd31, 1'b1, 11'h000, 1'b1, 13);

    // Output stall with a second operand waiting upstream.
    out_ready = 1'b0;
    accept(11'h155, 5'd0, 1'b0);
    wait_valid(e);
    chk("hold_lat", e, 2);
    @(negedge clk);
    mant_in = 11'h2AA; shamt = 5'd1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_mant", mant_out, 11'h155);
      chk("hold_sticky", sticky, 1'b0);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_release_valid", out_valid, 1'b0);
    chk("hold_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("hold_second_taken", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_valid(e);
    chk("second_lat", e, 3);
    chk("second_mant", mant_out, 11'h155);
    chk("second_sticky", sticky, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of SHIFT.
    accept(11'h7C0, 5'd6, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_mant", mant_out, 11'h000);
    chk("midrst_sticky", sticky, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("midrst_no_output", out_valid, 1'b0);
    end
    run_op("t6_after_rst", 11'h7C0, 5'd6, 1'b1, 11'h7E1, 1'b0, 8);

    run4("s4_overflow", 11'h7FF, 5'd31, 1'b1, 11'h000, 1'b1, 5);
    run4("s4_shift3",   11'h403, 5'd3,  1'b0, 11'h080, 1'b1, 3);
    run4("s4_shift9",   11'h600, 5'd9,  1'b0, 11'h003, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
